// File: rtl/perf_pkg.sv
// Shared constants for the performance-monitor bank: event bit assignment,
// default sizing and the address-width helper.
package perf_pkg;

    localparam int unsigned DEF_NUM_EVENTS = 8;
    localparam int unsigned DEF_CNT_WIDTH  = 32;

    localparam int unsigned EV_CYCLE        = 0;
    localparam int unsigned EV_INSTR        = 1;
    localparam int unsigned EV_STALL        = 2;
    localparam int unsigned EV_BRANCH       = 3;
    localparam int unsigned EV_MISPRED      = 4;
    localparam int unsigned EV_ICACHE_STALL = 5;

    // A single-channel bank still needs a 1-bit address.
    function automatic int unsigned addr_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/perf_counter.sv
// One performance counter channel: count register plus sticky overflow,
// with clear > write > increment priority.
module perf_counter
    import perf_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = DEF_CNT_WIDTH,
    parameter bit          SATURATE  = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 wr,
    input  logic [CNT_WIDTH-1:0] wr_data,
    input  logic                 inc,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 overflow
);

    localparam logic [CNT_WIDTH-1:0] ALL_ONES = '1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count    <= '0;
            overflow <= 1'b0;
        end else if (clear) begin
            count    <= '0;
            overflow <= 1'b0;
        end else if (wr) begin
            // overflow is deliberately left untouched by a preload
            count <= wr_data;
        end else if (inc) begin
            if (count == ALL_ONES) begin
                overflow <= 1'b1;
                if (!SATURATE) begin
                    count <= '0;
                end
            end else begin
                count <= count + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/perf_counter_bank.sv
// Bank of generic event counters with a shadow snapshot bank and a
// one-cycle registered read port over either bank.
module perf_counter_bank
    import perf_pkg::*;
#(
    parameter int unsigned  NUM_EVENTS = DEF_NUM_EVENTS,
    parameter int unsigned  CNT_WIDTH  = DEF_CNT_WIDTH,
    parameter bit           SATURATE   = 1'b0,
    localparam int unsigned AW         = addr_width(NUM_EVENTS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  count_en,
    input  logic [NUM_EVENTS-1:0] event_in,
    input  logic                  clear,
    input  logic                  snap,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [CNT_WIDTH-1:0]  wr_data,
    input  logic                  rd_en,
    input  logic [AW-1:0]         rd_addr,
    input  logic                  rd_shadow,
    output logic                  rd_valid,
    output logic [CNT_WIDTH-1:0]  rd_data,
    output logic [NUM_EVENTS-1:0] overflow,
    output logic                  ovf_any
);

    logic [CNT_WIDTH-1:0] live   [NUM_EVENTS];
    logic [CNT_WIDTH-1:0] shadow [NUM_EVENTS];
    logic [CNT_WIDTH-1:0] rd_sel;

    for (genvar g = 0; g < NUM_EVENTS; g++) begin : g_chan
        perf_counter #(
            .CNT_WIDTH (CNT_WIDTH),
            .SATURATE  (SATURATE)
        ) u_cnt (
            .clk      (clk),
            .reset    (reset),
            .clear    (clear),
            .wr       (wr_en && (wr_addr == AW'(g))),
            .wr_data  (wr_data),
            .inc      (count_en && event_in[g]),
            .count    (live[g]),
            .overflow (overflow[g])
        );
    end

    // Snapshot samples pre-edge live values, so same-cycle writes/clears are not seen.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_EVENTS; i++) begin
                shadow[i] <= '0;
            end
        end else if (snap) begin
            for (int i = 0; i < NUM_EVENTS; i++) begin
                shadow[i] <= live[i];
            end
        end
    end

    // Unpopulated addresses fall through to zero.
    always_comb begin
        rd_sel = '0;
        for (int i = 0; i < NUM_EVENTS; i++) begin
            if (rd_addr == AW'(i)) begin
                rd_sel = rd_shadow ? shadow[i] : live[i];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= rd_sel;
            end
        end
    end

    assign ovf_any = |overflow;

endmodule

// File: tb/tb_perf_counter_bank.sv
// Drives a wrapping 6x8-bit bank and a saturating 8x16-bit bank with shared
// stimulus and checks both against an array-based model every cycle.
module tb_perf_counter_bank;
    import perf_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        count_en, clear, snap, wr_en, rd_en, rd_shadow;
    logic [7:0]  event_in;
    logic [2:0]  wr_addr, rd_addr;
    logic [15:0] wr_data;

    logic        rd_valid_w, ovf_any_w, rd_valid_s, ovf_any_s;
    logic [7:0]  rd_data_w;
    logic [5:0]  ovf_w;
    logic [15:0] rd_data_s;
    logic [7:0]  ovf_s;

    int checks = 0;
    int errors = 0;

    // model state: index 0 = wrap bank, index 1 = saturate bank
    logic [15:0] m_live [2][8];
    logic [15:0] m_sh   [2][8];
    logic [7:0]  m_ovf  [2];
    logic        m_rv   [2];
    logic [15:0] m_rd   [2];

    always #5 clk = ~clk;

    perf_counter_bank #(.NUM_EVENTS(6), .CNT_WIDTH(8), .SATURATE(1'b0)) dut_w (
        .clk(clk), .reset(reset), .count_en(count_en), .event_in(event_in[5:0]),
        .clear(clear), .snap(snap), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data[7:0]), .rd_en(rd_en), .rd_addr(rd_addr), .rd_shadow(rd_shadow),
        .rd_valid(rd_valid_w), .rd_data(rd_data_w), .overflow(ovf_w), .ovf_any(ovf_any_w)
    );

    perf_counter_bank #(.NUM_EVENTS(8), .CNT_WIDTH(16), .SATURATE(1'b1)) dut_s (
        .clk(clk), .reset(reset), .count_en(count_en), .event_in(event_in),
        .clear(clear), .snap(snap), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr), .rd_shadow(rd_shadow),
        .rd_valid(rd_valid_s), .rd_data(rd_data_s), .overflow(ovf_s), .ovf_any(ovf_any_s)
    );

    function automatic int ne(input int d);
        return (d == 0) ? 6 : 8;
    endfunction

    function automatic logic [15:0] cmax(input int d);
        return (d == 0) ? 16'h00FF : 16'hFFFF;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // Reference model: reads and snapshots see old values, then counters update.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int d = 0; d < 2; d++) begin
                for (int i = 0; i < 8; i++) begin
                    m_live[d][i] = '0;
                    m_sh[d][i]   = '0;
                end
                m_ovf[d] = '0;
                m_rv[d]  = 1'b0;
                m_rd[d]  = '0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                m_rv[d] = rd_en;
                if (rd_en) begin
                    if (int'(rd_addr) < ne(d))
                        m_rd[d] = rd_shadow ? m_sh[d][rd_addr] : m_live[d][rd_addr];
                    else
                        m_rd[d] = '0;
                end
                if (snap)
                    for (int i = 0; i < ne(d); i++) m_sh[d][i] = m_live[d][i];
                for (int i = 0; i < ne(d); i++) begin
                    if (clear) begin
                        m_live[d][i] = '0;
                        m_ovf[d][i]  = 1'b0;
                    end else if (wr_en && int'(wr_addr) == i) begin
                        m_live[d][i] = wr_data & cmax(d);
                    end else if (count_en && event_in[i]) begin
                        if (m_live[d][i] == cmax(d)) begin
                            m_ovf[d][i] = 1'b1;
                            if (d == 0) m_live[d][i] = '0;
                        end else begin
                            m_live[d][i] = m_live[d][i] + 16'd1;
                        end
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("rd_valid_w", 16'(rd_valid_w), 16'(m_rv[0]));
        chk("rd_data_w",  16'(rd_data_w),  m_rd[0]);
        chk("ovf_w",      16'({2'b00, ovf_w}), 16'(m_ovf[0]));
        chk("ovf_any_w",  16'(ovf_any_w),  16'(|m_ovf[0]));
        chk("rd_valid_s", 16'(rd_valid_s), 16'(m_rv[1]));
        chk("rd_data_s",  rd_data_s,       m_rd[1]);
        chk("ovf_s",      16'(ovf_s),      16'(m_ovf[1]));
        chk("ovf_any_s",  16'(ovf_any_s),  16'(|m_ovf[1]));
    end

    task automatic defaults();
        count_en = 0; event_in = '0; clear = 0; snap = 0;
        wr_en = 0; wr_addr = '0; wr_data = '0;
        rd_en = 0; rd_addr = '0; rd_shadow = 0;
    endtask

    task automatic write(input logic [2:0] a, input logic [15:0] v);
        wr_en = 1; wr_addr = a; wr_data = v;
        @(negedge clk);
        wr_en = 0;
    endtask

    task automatic pulse(input int b, input int n);
        repeat (n) begin
            count_en = 1; event_in = '0; event_in[b] = 1'b1;
            @(negedge clk);
        end
        count_en = 0; event_in = '0;
    endtask

    task automatic do_clear();
        clear = 1;
        @(negedge clk);
        clear = 0;
    endtask

    task automatic rd(input string nm, input logic [2:0] a, input logic sh,
                      input logic [15:0] ew, input logic [15:0] es);
        rd_en = 1; rd_addr = a; rd_shadow = sh;
        @(negedge clk);
        rd_en = 0;
        chk({nm, "_w"}, 16'(rd_data_w), ew);
        chk({nm, "_s"}, rd_data_s, es);
        chk({nm, "_vld"}, 16'({rd_valid_w, rd_valid_s}), 16'h0003);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        defaults();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_outs_w", 16'({rd_valid_w, ovf_any_w, ovf_w}), 16'h0000);
        chk("reset_data_w", 16'(rd_data_w), 16'h0000);
        chk("reset_outs_s", 16'({rd_valid_s, ovf_any_s, ovf_s}), 16'h0000);
        chk("reset_data_s", rd_data_s, 16'h0000);
        reset = 1'b0;
        @(negedge clk);

        // wrap: FE + 3 events
        write(3'd2, 16'h00FE);
        pulse(2, 3);
        chk("wrap_ovf_w", 16'(ovf_w[2]), 16'h0001);
        chk("wrap_ovf_s", 16'(ovf_s[2]), 16'h0000);
        rd("wrap_val", 3'd2, 1'b0, 16'h0001, 16'h0101);
        write(3'd2, 16'h0010);
        chk("wr_keeps_ovf", 16'(ovf_w[2]), 16'h0001);
        rd("wr_val", 3'd2, 1'b0, 16'h0010, 16'h0010);

        // saturate: all-ones + 5 events
        write(3'd3, 16'hFFFF);
        pulse(3, 5);
        rd("sat_val", 3'd3, 1'b0, 16'h0004, 16'hFFFF);
        chk("sat_ovf_s", 16'(ovf_s[3]), 16'h0001);
        chk("sat_any", 16'({ovf_any_w, ovf_any_s}), 16'h0003);

        // clear beats events
        clear = 1; count_en = 1; event_in = 8'hFF;
        @(negedge clk);
        defaults();
        chk("clr_ovf", 16'({ovf_w, ovf_s}), 16'h0000);
        rd("clr_c0", 3'd0, 1'b0, 16'h0000, 16'h0000);
        rd("clr_c3", 3'd3, 1'b0, 16'h0000, 16'h0000);

        // write beats event
        wr_en = 1; wr_addr = 3'd1; wr_data = 16'h0100; count_en = 1; event_in = 8'h02;
        @(negedge clk);
        defaults();
        rd("wr_vs_ev", 3'd1, 1'b0, 16'h0000, 16'h0100);

        // snapshot
        do_clear();
        pulse(EV_CYCLE, 20);
        snap = 1;
        @(negedge clk);
        snap = 0;
        pulse(EV_CYCLE, 10);
        chk("model_sh0", m_sh[1][0], 16'd20);
        rd("snap_sh", 3'd0, 1'b1, 16'd20, 16'd20);
        rd("snap_live", 3'd0, 1'b0, 16'd30, 16'd30);
        do_clear();
        rd("snap_kept", 3'd0, 1'b1, 16'd20, 16'd20);

        // back-to-back reads
        write(3'd0, 16'h0011);
        write(3'd1, 16'h0022);
        write(3'd2, 16'h0033);
        rd_en = 1; rd_shadow = 0; rd_addr = 3'd0;
        @(negedge clk);
        rd_addr = 3'd1;
        chk("b2b0", 16'({rd_valid_w, rd_data_w}), 16'h0111);
        chk("b2b0_s", rd_data_s, 16'h0011);
        @(negedge clk);
        rd_addr = 3'd2;
        chk("b2b1", 16'({rd_valid_w, rd_data_w}), 16'h0122);
        @(negedge clk);
        rd_en = 0;
        chk("b2b2", 16'({rd_valid_s, rd_data_s[7:0]}), 16'h0133);
        @(negedge clk);
        chk("b2b_idle", 16'({rd_valid_w, rd_valid_s, rd_data_w}), 16'h0033);

        // out-of-range address on the 6-channel bank
        write(3'd7, 16'h0077);
        rd("oor7", 3'd7, 1'b0, 16'h0000, 16'h0077);

        // async reset with a pending read
        write(3'd4, 16'h0055);
        write(3'd5, 16'hFFFF);
        pulse(5, 1);
        rd_en = 1; rd_addr = 3'd4;
        @(negedge clk);
        chk("pre_rst", 16'({ovf_any_w, ovf_any_s, rd_valid_s, rd_data_w}), 16'h0755);
        #2 reset = 1'b1;
        #1;
        chk("async_w", 16'({rd_valid_w, ovf_any_w, ovf_w, rd_data_w}), 16'h0000);
        chk("async_s", 16'({rd_valid_s, ovf_any_s, ovf_s}), 16'h0000);
        chk("async_d", rd_data_s, 16'h0000);
        @(negedge clk);
        reset = 1'b0; rd_en = 0;
        @(negedge clk);
        chk("post_rst_vld", 16'({rd_valid_w, rd_valid_s}), 16'h0000);
        rd("post_rst_c4", 3'd4, 1'b0, 16'h0000, 16'h0000);

        // randomized traffic, checked cycle by cycle against the model
        repeat (3000) begin
            count_en  = ($urandom_range(0, 4) != 0);
            event_in  = 8'($urandom);
            clear     = ($urandom_range(0, 49) == 0);
            snap      = ($urandom_range(0, 11) == 0);
            wr_en     = ($urandom_range(0, 5) == 0);
            wr_addr   = 3'($urandom);
            case ($urandom_range(0, 3))
                0:       wr_data = 16'hFFFF - 16'($urandom_range(0, 3));
                1:       wr_data = 16'h00FF - 16'($urandom_range(0, 3));
                default: wr_data = 16'($urandom);
            endcase
            rd_en     = $urandom_range(0, 1) == 1;
            rd_addr   = 3'($urandom);
            rd_shadow = $urandom_range(0, 1) == 1;
            @(negedge clk);
        end
        defaults();
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
